if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
Instruction-fetch stage (IF plus IF/ID producer side) of the 5-stage MIPS pipeline. Holds the PC and drives the instruction SRAM request. Produces if_to_id_bus for the decode stage and consumes the decode stage's br_bus redirect. Guarantees that a redirect arriving while IF is stalled is never lost.

Parameters:
RESET_PC, 32'hBFBF_FFFC, PC value held in reset; the first fetched address is RESET_PC+4 = 32'hBFC0_0000.
STALL_BIT, 0, index in stall bus that freezes the PC.

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  asynchronous, active-high reset
stall  input  `StallBus (6)  pipeline stall vector; bit STALL_BIT==`Stop freezes IF
br_bus  input  `BR_WD (33)  {br_e[32], br_addr[31:0]} from decode stage
if_to_id_bus  output  `IF_TO_ID_WD (33)  {ce[32], pc[31:0]}
inst_sram_en  output  1  instruction SRAM enable
inst_sram_wen  output  4  always 4'b0
inst_sram_addr  output  32  fetch address
inst_sram_wdata  output  32  always 32'b0
if_adel  output  1  fetch address-error flag (see Optional Feature)

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high on rst.
- State:
  - pc_r[31:0]
  - ce_r
  - pend_v (pending redirect valid)
  - pend_addr[31:0]
- Reset (async, immediate): pc_r=RESET_PC, ce_r=0, pend_v=0, pend_addr=0.
  - During reset: outputs inst_sram_en=0, if_to_id_bus=33'b0 | RESET_PC (ce bit 0), if_adel=0.
  - Asserting rst mid-operation aborts any pending redirect.
- next_pc priority:
  1. live br_e=1: br_addr
  2. else pend_v=1: pend_addr
  3. else: pc_r+32'd4. Plain 32-bit add; wraps 32'hFFFF_FFFC to 32'h0000_0000 with no flag.
- Posedge clk, not in reset:
  - stall[STALL_BIT]==`NoStop:
    - ce_r<=1, pc_r<=next_pc.
    - pend_v<=0.
  - stall[STALL_BIT]==`Stop:
    - pc_r and ce_r hold.
    - If br_e=1: pend_v<=1, pend_addr<=br_addr. A later br_e during the same stall overwrites pend_addr.
    - Else pend_v and pend_addr hold.
- Outputs (combinational from registers):
  - inst_sram_en = ce_r & ~if_adel
  - inst_sram_addr = pc_r
  - if_to_id_bus = {ce_r, pc_r}
- Latency:
  - br_e sampled at edge N (unstalled): pc_r=br_addr after edge N, SRAM request the same cycle.
  - The delay-slot instruction is already in flight (pc_r before edge N); IF neither squashes nor flushes it.
- First cycle after reset release: ce_r=0, so decode sees a bubble. The edge after that fetches 32'hBFC0_0000.
- br_e with ce_r=0 (bubble) is still honoured. Decode is responsible for gating br_e on ce.

Optional Feature:
Macro IF_ADEL_CHECK_EN.
- Defined: if_adel = ce_r & (pc_r[1:0]!=2'b00).
  - When if_adel=1, inst_sram_en is forced 0.
  - if_to_id_bus still carries {ce_r, pc_r} so a later exception stage can report BadVAddr.
  - The PC keeps advancing normally.
- Not defined: if_adel tied to 0; inst_sram_en = ce_r.

Test Plan:
- Reset then release, no stall, no branch:
  - cycle 1: ce=0, pc=BFBF_FFFC, en=0
  - then pc=BFC0_0000, BFC0_0004, BFC0_0008 with en=1 each cycle.
- br_bus={1, 32'hBFC0_0100} for one cycle while pc=BFC0_0008 -> next pc=BFC0_0100, following pc=BFC0_0104.
- Stall held 3 cycles at pc=BFC0_0010 -> pc, ce and sram_addr are constant for all 3 cycles; resumes at BFC0_0014.
- Redirect during stall:
  - stall asserted at pc=BFC0_0020, br_bus={1, BFC0_0200} pulsed in the 2nd stall cycle, stall released 2 cycles later.
  - Required: first unstalled edge gives pc=BFC0_0200, then pend_v=0 and the next pc=BFC0_0204.
- Async rst pulsed mid-cycle while pend_v=1 at pc=BFC0_0300 -> immediately pc=BFBF_FFFC, ce=0, en=0; after release, fetch restarts at BFC0_0000 (pending target discarded).
- With IF_ADEL_CHECK_EN, br_addr=BFC0_0102 -> pc=BFC0_0102, if_adel=1, inst_sram_en=0, if_to_id_bus={1, BFC0_0102}. Without the macro: if_adel=0, en=1.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage signal bundle: stall vector, decode redirect, IF/ID bus, instruction SRAM request.
// Latency: none; wires only.
// Backpressure: stall vector from the pipeline controller freezes the fetch side.

`ifndef StallBus
`define StallBus 6
`endif
`ifndef BR_WD
`define BR_WD 33
`endif
`ifndef IF_TO_ID_WD
`define IF_TO_ID_WD 33
`endif
`ifndef Stop
`define Stop 1'b1
`endif
`ifndef NoStop
`define NoStop 1'b0
`endif

interface if_fetch_unit_if;
    // Pipeline stall vector; one bit per stage.
    logic [`StallBus-1:0]    stall;
    // {br_e, br_addr} redirect from decode.
    logic [`BR_WD-1:0]       br_bus;
    // {ce, pc} towards decode.
    logic [`IF_TO_ID_WD-1:0] if_to_id_bus;
    // Instruction SRAM request (read-only port usage).
    logic                    inst_sram_en;
    logic [3:0]              inst_sram_wen;
    logic [31:0]             inst_sram_addr;
    logic [31:0]             inst_sram_wdata;
    // Fetch address error flag.
    logic                    if_adel;

    // Fetch unit side.
    modport master (
        input  stall,
        input  br_bus,
        output if_to_id_bus,
        output inst_sram_en,
        output inst_sram_wen,
        output inst_sram_addr,
        output inst_sram_wdata,
        output if_adel
    );

    // Environment side (decode stage, SRAM, stall controller).
    modport slave (
        output stall,
        output br_bus,
        input  if_to_id_bus,
        input  inst_sram_en,
        input  inst_sram_wen,
        input  inst_sram_addr,
        input  inst_sram_wdata,
        input  if_adel
    );
endinterface

// File: rtl/if_fetch_unit.sv
// MIPS instruction fetch: holds the PC, issues the SRAM read, latches redirects seen during stalls.
// Latency: redirect sampled at an unstalled edge becomes pc/SRAM address right after that edge.
// Backpressure: stall[STALL_BIT] freezes pc/ce; redirects arriving meanwhile are held until release.
// Optional macro IF_ADEL_CHECK_EN enables the misaligned-fetch (AdEL) flag and SRAM gating.

`ifndef StallBus
`define StallBus 6
`endif
`ifndef BR_WD
`define BR_WD 33
`endif
`ifndef IF_TO_ID_WD
`define IF_TO_ID_WD 33
`endif
`ifndef Stop
`define Stop 1'b1
`endif
`ifndef NoStop
`define NoStop 1'b0
`endif

module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'hBFBF_FFFC,
    parameter int          STALL_BIT = 0
) (
    input  logic          clk,
    input  logic          rst,
    if_fetch_unit_if.master bus
);

    // Architectural fetch state.
    logic [31:0] pc_r;
    logic        ce_r;

    // A redirect that arrived while IF was stalled; replayed on release.
    logic        pend_v;
    logic [31:0] pend_addr;

    // Decoded redirect and stall inputs.
    logic        br_e;
    logic [31:0] br_addr;
    logic        stall_if;
    logic [31:0] next_pc;
    logic        adel;

    assign br_e     = bus.br_bus[32];
    assign br_addr  = bus.br_bus[31:0];
    assign stall_if = bus.stall[STALL_BIT];

    // Only one stall bit matters here; the rest of the vector belongs to later stages.
    logic unused_stall_bits;
    assign unused_stall_bits = ^bus.stall;

    // Next PC selection: a live redirect beats a remembered one, which beats sequential fetch.
    // The +4 wraps silently at the top of the address space.
    always_comb begin
        next_pc = pc_r + 32'd4;
        if (br_e) begin
            next_pc = br_addr;
        end else if (pend_v) begin
            next_pc = pend_addr;
        end
    end

    // PC, fetch-valid and pending-redirect registers; reset drops any pending redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r      <= RESET_PC;
            ce_r      <= 1'b0;
            pend_v    <= 1'b0;
            pend_addr <= 32'h0;
        end else if (stall_if == `NoStop) begin
            ce_r   <= 1'b1;
            pc_r   <= next_pc;
            pend_v <= 1'b0;
        end else if (br_e) begin
            // The latest redirect seen during a stall wins.
            pend_v    <= 1'b1;
            pend_addr <= br_addr;
        end
    end

`ifdef IF_ADEL_CHECK_EN
    // Misaligned fetch: flag it and suppress the SRAM access, but keep pc visible to decode.
    assign adel = ce_r & (pc_r[1:0] != 2'b00);
`else
    // Alignment is not checked in this build.
    logic unused_pc_low;
    assign unused_pc_low = ^pc_r[1:0];
    assign adel = 1'b0;
`endif

    // Outputs are pure functions of registered state.
    assign bus.if_adel         = adel;
    assign bus.inst_sram_en    = ce_r & ~adel;
    assign bus.inst_sram_wen   = 4'b0000;
    assign bus.inst_sram_addr  = pc_r;
    assign bus.inst_sram_wdata = 32'h0;
    assign bus.if_to_id_bus    = {ce_r, pc_r};

endmodule
